svc_axi_mem: RTL

SVC_AXI_MEM -- requirements
Module: svc_axi_mem

---
 rtl/svc_axi_pkg.sv | 33 +++
 rtl/svc_axi_burst_addr.sv | 32 +++
 rtl/svc_axi_mem.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/svc_axi_pkg.sv
// Shared AXI encodings and FSM state types for the svc_axi memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package svc_axi_pkg;

    // AXI burst type encodings; RSVD is carried so it can be recognised and rejected.
    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Only FIXED and INCR bursts are serviced; WRAP and reserved are errored.
    function automatic logic burst_supported(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

endpackage

// File: rtl/svc_axi_burst_addr.sv
// Per-beat next word address and burst legality for one AXI channel.
// Latency: purely combinational.
// Backpressure: none; the owning FSM decides when the next address is taken.
//
// Ports: cur_addr  - word address of the current beat
//        burst     - AXI burst type of the burst in progress
//        next_addr - word address of the following beat (wraps modulo depth)
//        burst_err - burst type is not serviced (WRAP or reserved)
module svc_axi_burst_addr
    import svc_axi_pkg::*;
#(
    parameter int WORD_AW = 9
) (
    input  logic [WORD_AW-1:0] cur_addr,
    input  logic [1:0]         burst,
    output logic [WORD_AW-1:0] next_addr,
    output logic               burst_err
);

    localparam logic [WORD_AW-1:0] ONE = {{(WORD_AW-1){1'b0}}, 1'b1};

    // WRAP and reserved step like INCR; their writes are suppressed elsewhere.
    // The add naturally wraps at the top of the array.
    always_comb begin
        next_addr = cur_addr + ONE;
        if (burst == BURST_FIXED) begin
            next_addr = cur_addr;
        end
        burst_err = !burst_supported(burst);
    end

endmodule

// File: rtl/svc_axi_mem.sv
// AXI4 slave responder over an internal word array, independent write and read FSMs.
// Latency: AW->B at least len+2 cycles; AR->first R beat next cycle, then one beat/cycle.
// Backpressure: one outstanding burst per channel; B held until bready, R held while !rready.
//
// Ports: clk, rst_n (synchronous, active-low)
//        s_axi_aw*  - write address channel (awsize ignored)
//        s_axi_w*   - write data channel, byte strobes honoured
//        s_axi_b*   - write response (bid = awid, SLVERR on bad burst or wlast misplacement)
//        s_axi_ar*  - read address channel (arsize ignored)
//        s_axi_r*   - read data channel, all payload registered
module svc_axi_mem
    import svc_axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 10,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,

    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,

    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,

    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,

    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast
);

    localparam int STRB_W  = AXI_DATA_WIDTH / 8;
    localparam int BSHIFT  = $clog2(STRB_W);
    localparam int WORD_AW = AXI_ADDR_WIDTH - BSHIFT;
    localparam int DEPTH   = 1 << WORD_AW;

    // Array contents survive reset, so no reset on the storage.
    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    // Size is ignored (every beat full width) and sub-word address bits are dropped.
    logic unused_ok;
    assign unused_ok = ^{s_axi_awsize, s_axi_arsize, s_axi_awaddr, s_axi_araddr};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_e                 wstate;
    logic [WORD_AW-1:0]        waddr;
    logic [AXI_ID_WIDTH-1:0]   wid;
    logic [7:0]                wlen;
    logic [7:0]                wbeat;
    logic [1:0]                wburst;
    logic                      wburst_err;
    logic                      wlast_err;

    logic [WORD_AW-1:0]        w_cur;
    logic [1:0]                w_burst_sel;
    logic [WORD_AW-1:0]        w_next;
    logic                      w_err;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      mem_we;

    // While idle the address unit looks at the incoming AW so legality can be
    // latched with the handshake; afterwards it tracks the burst in progress.
    assign w_cur       = (wstate == W_IDLE) ? s_axi_awaddr[AXI_ADDR_WIDTH-1:BSHIFT] : waddr;
    assign w_burst_sel = (wstate == W_IDLE) ? s_axi_awburst : wburst;

    svc_axi_burst_addr #(
        .WORD_AW   (WORD_AW)
    ) u_wr_addr (
        .cur_addr  (w_cur),
        .burst     (w_burst_sel),
        .next_addr (w_next),
        .burst_err (w_err)
    );

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    // rst_n gate: a beat arriving on the reset edge belongs to an abandoned burst.
    assign mem_we = rst_n && w_hs && !wburst_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wstate        <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_bid     <= '0;
            waddr         <= '0;
            wid           <= '0;
            wlen          <= '0;
            wbeat         <= '0;
            wburst        <= '0;
            wburst_err    <= 1'b0;
            wlast_err     <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (aw_hs) begin
                        waddr         <= w_cur;
                        wid           <= s_axi_awid;
                        wlen          <= s_axi_awlen;
                        wburst        <= s_axi_awburst;
                        wburst_err    <= w_err;
                        wlast_err     <= 1'b0;
                        wbeat         <= '0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        wstate        <= W_DATA;
                    end else begin
                        s_axi_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        waddr <= w_next;
                        wbeat <= wbeat + 8'd1;
                        // Completion follows the beat count; wlast only grades the burst.
                        if (wbeat == wlen) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bid    <= wid;
                            s_axi_bresp  <= (wburst_err || wlast_err || !s_axi_wlast)
                                            ? RESP_SLVERR : RESP_OKAY;
                            wstate       <= W_RESP;
                        end else if (s_axi_wlast) begin
                            wlast_err <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_bresp   <= RESP_OKAY;
                        s_axi_awready <= 1'b1;
                        wstate        <= W_IDLE;
                    end
                end
                default: begin
                    wstate <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_e                 rstate;
    logic [WORD_AW-1:0]        raddr;
    logic [1:0]                rburst;
    logic [7:0]                rbeats_left;

    logic [WORD_AW-1:0]        r_cur;
    logic [1:0]                r_burst_sel;
    logic [WORD_AW-1:0]        r_next;
    logic                      r_err;
    logic                      ar_hs;

    assign r_cur       = (rstate == R_IDLE) ? s_axi_araddr[AXI_ADDR_WIDTH-1:BSHIFT] : raddr;
    assign r_burst_sel = (rstate == R_IDLE) ? s_axi_arburst : rburst;

    svc_axi_burst_addr #(
        .WORD_AW   (WORD_AW)
    ) u_rd_addr (
        .cur_addr  (r_cur),
        .burst     (r_burst_sel),
        .next_addr (r_next),
        .burst_err (r_err)
    );

    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // The first beat is fetched on the AR handshake itself so rvalid rises the
    // very next cycle. Array reads see pre-write contents on a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rstate        <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            raddr         <= '0;
            rburst        <= '0;
            rbeats_left   <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        s_axi_rdata   <= mem[r_cur];
                        s_axi_rid     <= s_axi_arid;
                        s_axi_rresp   <= r_err ? RESP_SLVERR : RESP_OKAY;
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        s_axi_rvalid  <= 1'b1;
                        raddr         <= r_next;
                        rburst        <= s_axi_arburst;
                        rbeats_left   <= s_axi_arlen;
                        s_axi_arready <= 1'b0;
                        rstate        <= R_DATA;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (!s_axi_rvalid || s_axi_rready) begin
                        if (rbeats_left != 8'd0) begin
                            s_axi_rdata  <= mem[r_cur];
                            s_axi_rlast  <= (rbeats_left == 8'd1);
                            s_axi_rvalid <= 1'b1;
                            raddr        <= r_next;
                            rbeats_left  <= rbeats_left - 8'd1;
                        end else begin
                            // Last beat accepted: burst done.
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_rresp   <= RESP_OKAY;
                            s_axi_arready <= 1'b1;
                            rstate        <= R_IDLE;
                        end
                    end
                end
                default: begin
                    rstate <= R_IDLE;
                end
            endcase
        end
    end

endmodule
